// File: rtl/reg_exec_stage_pkg.sv
// rtl/reg_exec_stage_pkg.sv - shared widths and ALU op encodings for the execute stage
package reg_exec_stage_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9
    } alu_op_e;

    function automatic logic is_legal_op(input logic [4:0] op);
        return (op <= 5'd9);
    endfunction

endpackage

// File: rtl/reg_exec_stage_regfile.sv
// rtl/reg_exec_stage_regfile.sv - 32x32 register file, two read ports plus debug read, x0 fixed at zero
module reg_file_32x32
    import reg_exec_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr1,
    output logic [XLEN-1:0]   rdata1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata2,
    input  logic [REG_AW-1:0] dbg_raddr,
    output logic [XLEN-1:0]   dbg_rdata,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Index 0 is gated on read as well so x0 is zero regardless of storage.
    assign rdata1    = (raddr1 == '0)    ? '0 : regs_q[raddr1];
    assign rdata2    = (raddr2 == '0)    ? '0 : regs_q[raddr2];
    assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs_q[dbg_raddr];

endmodule

// File: rtl/reg_exec_stage.sv
// rtl/reg_exec_stage.sv - execute stage: regfile read, ALU, write-back and registered result port
module reg_exec_stage
    import reg_exec_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [4:0]        alu_control,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_rd,
    output logic [XLEN-1:0]   out_result,
    output logic              out_illegal,
    input  logic [REG_AW-1:0] dbg_raddr,
    output logic [XLEN-1:0]   dbg_rdata,
    output logic [31:0]       retire_cnt
);

    logic              out_valid_q,   out_valid_d;
    logic [REG_AW-1:0] out_rd_q,      out_rd_d;
    logic [XLEN-1:0]   out_result_q,  out_result_d;
    logic              out_illegal_q, out_illegal_d;
    logic [31:0]       retire_cnt_q,  retire_cnt_d;

    logic              accept;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   alu_result;
    logic              alu_illegal;
    logic [4:0]        shamt;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    reg_file_32x32 u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr1    (rs1),
        .rdata1    (op1),
        .raddr2    (rs2),
        .rdata2    (op2),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .we        (accept && !alu_illegal),
        .waddr     (rd),
        .wdata     (alu_result)
    );

    assign shamt = op2[4:0];

    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (alu_control)
            ALU_ADD:  alu_result = op1 + op2;
            ALU_SUB:  alu_result = op1 - op2;
            ALU_SLL:  alu_result = op1 << shamt;
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (op1 < op2)};
            ALU_XOR:  alu_result = op1 ^ op2;
            ALU_SRL:  alu_result = op1 >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(op1) >>> shamt);
            ALU_OR:   alu_result = op1 | op2;
            ALU_AND:  alu_result = op1 & op2;
            default:  alu_illegal = 1'b1;
        endcase
    end

    // A new accept overrides a simultaneous drain, so out_valid stays high.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_rd_d      = out_rd_q;
        out_result_d  = out_result_q;
        out_illegal_d = out_illegal_q;
        retire_cnt_d  = retire_cnt_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_rd_d      = rd;
            out_result_d  = alu_result;
            out_illegal_d = alu_illegal;
            retire_cnt_d  = retire_cnt_q + 32'd1;
        end else if (out_ready) begin
            out_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_rd_q      <= '0;
            out_result_q  <= '0;
            out_illegal_q <= 1'b0;
            retire_cnt_q  <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_rd_q      <= out_rd_d;
            out_result_q  <= out_result_d;
            out_illegal_q <= out_illegal_d;
            retire_cnt_q  <= retire_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_rd      = out_rd_q;
    assign out_result  = out_result_q;
    assign out_illegal = out_illegal_q;
    assign retire_cnt  = retire_cnt_q;

endmodule
